// File: rtl/commit_trace_checker.sv
// Compares the CPU commit stream against an expected-trace record stream and
// reports pass/fail, the first mismatching record and which fields differed.
module commit_trace_checker #(
    parameter int DEPTH      = 4,
    parameter int MAX_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic [31:0] pc,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        halt,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [2:0]  exp_kind,
    input  logic [31:0] exp_pc,
    input  logic [4:0]  exp_reg,
    input  logic [31:0] exp_value,
    input  logic [31:0] exp_addr,
    output logic [31:0] inum,
    output logic        done,
    output logic        pass,
    output logic        mismatch,
    output logic [31:0] mism_inum,
    output logic [4:0]  mism_field,
    output logic        overflow,
    output logic        timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE     = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] PTR_DEPTH   = (PTR_W + 1)'(DEPTH);
    localparam logic [31:0]    CYCLE_LIMIT = 32'(MAX_CYCLES - 1);

    localparam logic [2:0] K_NOP   = 3'd0;
    localparam logic [2:0] K_REG   = 3'd1;
    localparam logic [2:0] K_LOAD  = 3'd2;
    localparam logic [2:0] K_STORE = 3'd3;
    localparam logic [2:0] K_HALT  = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] addr;
    } rec_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_e;

    state_e         state_q, state_d;
    rec_t           fifo_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]    cycle_q, cycle_d;
    logic [31:0]    inum_q, inum_d;
    logic           mismatch_q, mismatch_d;
    logic [31:0]    mism_inum_q, mism_inum_d;
    logic [4:0]     mism_field_q, mism_field_d;
    logic           overflow_q, overflow_d;
    logic           timeout_q, timeout_d;

    logic           run, empty, full, fire, push, drop;
    logic           mism_hit, pass_hit, timeout_hit;
    logic [2:0]     commit_kind;
    logic [4:0]     field;
    rec_t           push_rec, head;

    assign run       = (state_q == ST_RUN);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = ((wr_ptr_q - rd_ptr_q) == PTR_DEPTH);
    assign exp_ready = run && !empty;
    assign fire      = exp_valid && exp_ready;
    // A pop in the same cycle frees the slot, so a retire at full is only lost without a fire.
    assign push      = retire && run && (!full || fire);
    assign drop      = retire && run && full && !fire;
    assign head      = fifo_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        commit_kind = K_NOP;
        if (halt)                       commit_kind = K_HALT;
        else if (mem_write)             commit_kind = K_STORE;
        else if (reg_write && mem_read) commit_kind = K_LOAD;
        else if (reg_write)             commit_kind = K_REG;
    end

    always_comb begin
        push_rec.kind  = commit_kind;
        push_rec.pc    = pc;
        push_rec.rd    = write_reg;
        push_rec.value = (commit_kind == K_STORE) ? mem_data : write_data;
        push_rec.addr  = mem_addr;
    end

    // Field checks depend on the kind; a kind difference reports only kind and pc.
    always_comb begin
        field    = '0;
        field[0] = (head.kind != exp_kind);
        field[1] = (head.pc != exp_pc);
        if (!field[0]) begin
            if (head.kind == K_REG || head.kind == K_LOAD)
                field[2] = (head.rd != exp_reg);
            if (head.kind == K_REG || head.kind == K_LOAD || head.kind == K_STORE)
                field[3] = (head.value != exp_value);
            if (head.kind == K_LOAD || head.kind == K_STORE)
                field[4] = (head.addr != exp_addr);
        end
    end

    assign mism_hit    = fire && (field != 5'd0);
    assign pass_hit    = fire && (field == 5'd0) && (head.kind == K_HALT);
    assign timeout_hit = run && (cycle_q == CYCLE_LIMIT);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cycle_d      = cycle_q;
        inum_d       = inum_q;
        mismatch_d   = mismatch_q;
        mism_inum_d  = mism_inum_q;
        mism_field_d = mism_field_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        if (run) begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                inum_d   = inum_q + 32'd1;
            end
            if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
            if (mism_hit) begin
                mismatch_d   = 1'b1;
                mism_inum_d  = inum_q;
                mism_field_d = field;
            end
            if (drop)        overflow_d = 1'b1;
            if (timeout_hit) timeout_d  = 1'b1;
            if (mism_hit || drop || timeout_hit) state_d = ST_FAIL;
            else if (pass_hit)                   state_d = ST_PASS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cycle_q      <= '0;
            inum_q       <= '0;
            mismatch_q   <= 1'b0;
            mism_inum_q  <= '0;
            mism_field_q <= '0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cycle_q      <= cycle_d;
            inum_q       <= inum_d;
            mismatch_q   <= mismatch_d;
            mism_inum_q  <= mism_inum_d;
            mism_field_q <= mism_field_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= push_rec;
    end

    assign inum       = inum_q;
    assign done       = !run;
    assign pass       = (state_q == ST_PASS);
    assign mismatch   = mismatch_q;
    assign mism_inum  = mism_inum_q;
    assign mism_field = mism_field_q;
    assign overflow   = overflow_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/commit_trace_checker.md
Name: commit_trace_checker

Overview:
- Synthesizable checker that consumes the CPU's per-cycle commit signals and compares them against an expected-trace record stream.
- The expected stream arrives over a valid/ready interface from a trace ROM or DMA.
- It reports pass/fail, the first mismatching instruction number, and which fields differed.
- It sits beside cpu_top in FPGA and emulation builds and replaces file-based trace diffing.

Parameters:
DEPTH, 4, commit FIFO entries (power of 2, >=2)
MAX_CYCLES, 100000, watchdog limit in cycles while running
Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
retire  input  1  an instruction commits this cycle
pc  input  32  committing PC
reg_write  input  1  register file written
write_reg  input  5  destination register
write_data  input  32  register write data
mem_read  input  1  load
mem_write  input  1  store
mem_addr  input  32  memory address
mem_data  input  32  store data
halt  input  1  halt committing
exp_valid  input  1  expected record valid
exp_ready  output  1  checker accepts expected record
exp_kind  input  3  0 NOP/branch, 1 REG, 2 LOAD, 3 STORE, 4 HALT
exp_pc  input  32  expected PC
exp_reg  input  5  expected destination register
exp_value  input  32  expected write/store data
exp_addr  input  32  expected memory address
inum  output  32  records compared
done  output  1  checking finished
pass  output  1  finished with no error
mismatch  output  1  sticky; a compare failed
mism_inum  output  32  inum of the first mismatch
mism_field  output  5  bit0 kind, bit1 pc, bit2 reg, bit3 value, bit4 addr
overflow  output  1  sticky; a commit was lost because the FIFO was full
timeout  output  1  sticky; watchdog expired

Behaviour:
- Reset: all outputs 0, FIFO empty, cycle counter 0, state RUN. Reset mid-run clears everything on the next edge.
- Commit kind priority: halt gives 4. Otherwise mem_write gives 3. Otherwise reg_write&mem_read gives 2. Otherwise reg_write gives 1. Otherwise 0.
- FIFO push:
  - When retire=1 and state is RUN, push {kind, pc, write_reg, value, mem_addr}.
  - value = mem_data for kind 3, write_data otherwise.
- Flow control:
  - exp_ready = (state==RUN) && FIFO non-empty. It is combinational and does not depend on exp_valid.
  - Fire = exp_valid && exp_ready. A fire pops the head and performs a compare.
- Compare rules:
  - The kind mismatch bit is always checked. The pc mismatch bit is always checked.
  - reg is checked for kinds 1 and 2.
  - value is checked for kinds 1, 2 and 3.
  - addr is checked for kinds 2 and 3.
  - If kinds differ, only the kind and pc bits are reported.
- Latency: a retire at cycle t is comparable at cycle t+1 at the earliest. Results register on the edge ending the fire cycle.
- Counting: inum increments on each fire. It includes the mismatching record and freezes after done.
- State RUN to FAIL (done=1, pass=0), on any of:
  - A fire with any mism_field bit set. Capture mism_inum = inum before the increment, capture mism_field, set mismatch.
  - retire while the FIFO is full with no fire that cycle. Set overflow; the record is dropped.
  - The cycle counter reaching MAX_CYCLES-1. Set timeout.
- Simultaneous events:
  - Push and pop in the same cycle are legal at full and at empty+1; neither case is an overflow.
  - Priority when several failures occur in one cycle: mismatch, then overflow, then timeout. All applicable sticky flags still set.
- State RUN to PASS (done=1, pass=1): a fire where both records are kind 4 with matching pc.
- PASS and FAIL are terminal until rst:
  - exp_ready=0.
  - retire is ignored.
  - The cycle counter stops.
- Cycle counter: counts every cycle in RUN, is 32 bits and saturates.
- Empty-FIFO HALT: no compare occurs until the commit arrives.

Test Plan:
- REG r3=0x5 at pc 0x0, STORE addr 0x100 val 0xAB at pc 0x4, HALT at pc 0x8; matching expected records streamed -> pass=1, done=1, inum=3, mismatch=0.
- Same program, expected STORE value 0xAC -> done=1, pass=0, mism_inum=1, mism_field=5'b01000; later HALT ignored, inum stays 2.
- DEPTH=4: four back-to-back retires with exp_valid=0, then expected records supplied -> no overflow, all compared. Fifth retire while full -> overflow=1, FAIL.
- FIFO full, retire and fire in the same cycle -> overflow=0, occupancy stays 4.
- MAX_CYCLES=20, no halt ever committed -> timeout=1, done=1 after 20 cycles in RUN, exp_ready=0 afterwards.
- Assert rst mid-run after a mismatch -> next cycle all outputs 0, state RUN; a matching rerun then passes.
